mem_copy_dma: RTL



---
 rtl/mem_bus_pkg.sv | 21 ++
 rtl/mem_copy_dma.sv | 118 +++++++++++
 2 files changed

// File: rtl/mem_bus_pkg.sv
// Shared memory-bus constants, DMA state encoding and opcodes.
// Imported by the copy engine, the micro core and benches.
package mem_bus_pkg;

  localparam int AW_DEF = 6;
  localparam int DW_DEF = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [1:0] LOADINS   = 2'b00;
  localparam logic [1:0] ADDINS    = 2'b01;
  localparam logic [1:0] STOREINS  = 2'b10;
  localparam logic [1:0] BRANCHINS = 2'b11;

endpackage

// File: rtl/mem_copy_dma.sv
// Block copy engine on the external memory bus: read then write per byte.
// MEM_COPY_WRITE_GUARD_EN adds an idle GAP cycle after every write.
module mem_copy_dma
  import mem_bus_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_read,
  output logic          mem_write,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};

  state_t        state, state_n;
  logic [AW:0]   idx, idx_n;
  logic [AW:0]   len_q, len_n;
  logic [AW:0]   len_sat;
  logic [AW-1:0] src_q, src_n;
  logic [AW-1:0] dst_q, dst_n;

  assign len_sat = (len > LEN_MAX) ? LEN_MAX : len;

  // Next state, byte index and captured transfer descriptor.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    src_n   = src_q;
    dst_n   = dst_q;
    len_n   = len_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (len_sat != '0) begin
            state_n = RD;
            src_n   = src;
            dst_n   = dst;
            len_n   = len_sat;
            idx_n   = '0;
          end else begin
            state_n = DONE;
          end
        end
      end
      RD: state_n = WR;
      WR: begin
        idx_n = idx + 1'b1;
`ifdef MEM_COPY_WRITE_GUARD_EN
        state_n = GAP;
`else
        state_n = (idx_n < len_q) ? RD : DONE;
`endif
      end
      GAP:  state_n = (idx < len_q) ? RD : DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State and registered bus outputs, decoded from the next state.
  // mem_din doubles as the data register: it captures mem_dout as RD
  // closes and keeps it through WR (and GAP when enabled).
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      len_q     <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      len_q     <= len_n;
      src_q     <= src_n;
      dst_q     <= dst_n;
      busy      <= (state_n != IDLE);
      done      <= (state_n == DONE);
      mem_read  <= (state_n == RD);
      mem_write <= (state_n == WR);
      unique case (state_n)
        RD: begin
          mem_addr <= src_n + idx_n[AW-1:0];
          mem_din  <= '0;
        end
        WR: begin
          mem_addr <= dst_n + idx_n[AW-1:0];
          mem_din  <= mem_dout;
        end
        GAP: begin
          mem_addr <= mem_addr;
          mem_din  <= mem_din;
        end
        default: begin
          mem_addr <= '0;
          mem_din  <= '0;
        end
      endcase
    end
  end

endmodule
